// File: rtl/inc_share_arbiter_pkg.sv
// Shared types and helpers for the shared-incrementer arbiter.
// Winner search and one-hot encoding work on an 8-channel superset.
package inc_share_arbiter_pkg;

   localparam int NCH_DEF = 4;
   localparam int W_DEF   = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_e;

   // First set bit of req scanning ptr, ptr+1, ... modulo nch
   function automatic logic [2:0] rr_winner(
      input logic [7:0] req,
      input logic [2:0] ptr,
      input logic [3:0] nch
   );
      logic [2:0] win;
      logic       found;
      logic [3:0] idx;
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         idx = {1'b0, ptr} + 4'(i);
         if (idx >= nch) idx = idx - nch;
         if (4'(i) < nch && !found && req[idx[2:0]]) begin
            win   = idx[2:0];
            found = 1'b1;
         end
      end
      return win;
   endfunction

   function automatic logic [7:0] onehot8(input logic [2:0] idx);
      return 8'b1 << idx;
   endfunction

endpackage

// File: rtl/inc_share_arbiter_if.sv
// Requester-side bundle of the shared-incrementer arbiter.
interface inc_share_arbiter_if #(
   parameter int NCH = 4,
   parameter int W   = 4
);
   logic [NCH-1:0]   req;
   logic [NCH-1:0]   clr;
   logic [NCH-1:0]   gnt;
   logic [NCH*W-1:0] cnt;
   logic [NCH-1:0]   ovf;
   logic             busy;

   modport master (
      output req, clr,
      input  gnt, cnt, ovf, busy
   );

   modport slave (
      input  req, clr,
      output gnt, cnt, ovf, busy
   );
endinterface

// File: rtl/inc_share_arbiter_ripple_incrementer.sv
// W-bit +1 incrementer built from a chain of half adders.
module ripple_incrementer #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   output logic [W-1:0] s,
   output logic         c
);
   logic [W:0] cy;

   assign cy[0] = 1'b1;

   for (genvar i = 0; i < W; i++) begin : g_ha
      assign s[i]    = a[i] ^ cy[i];
      assign cy[i+1] = a[i] & cy[i];
   end

   assign c = cy[W];
endmodule

// File: rtl/inc_share_arbiter.sv
// Round-robin sharing of one incrementer among NCH count registers.
// Each grant is a one-cycle EXEC that writes cnt[sel]+1 back.
module inc_share_arbiter
   import inc_share_arbiter_pkg::*;
#(
   parameter int NCH = NCH_DEF,
   parameter int W   = W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   inc_share_arbiter_if.slave bus
);
   localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

   state_e                 state_q, state_d;
   logic [SW-1:0]          ptr_q, ptr_d;
   logic [SW-1:0]          sel_q, sel_d;
   logic [SW-1:0]          win;
   logic [NCH-1:0]         gnt_q, gnt_d;
   logic [NCH-1:0]         ovf_q, ovf_d;
   logic                   busy_q, busy_d;
   logic [NCH-1:0][W-1:0]  cnt_q, cnt_d;
   logic [W-1:0]           inc_s;
   logic                   inc_c;

   assign win = SW'(rr_winner(8'(bus.req), 3'(ptr_q), 4'(NCH)));

   ripple_incrementer #(.W(W)) u_inc (
      .a (cnt_q[sel_q]),
      .s (inc_s),
      .c (inc_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         gnt_q   <= '0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         ovf_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (|bus.req) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      gnt_d  = '0;
      busy_d = 1'b0;
      sel_d  = sel_q;
      ptr_d  = ptr_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      unique case (state_q)
         ST_IDLE: begin
            if (|bus.req) begin
               sel_d  = win;
               gnt_d  = NCH'(onehot8(3'(win)));
               busy_d = 1'b1;
            end
         end
         ST_EXEC: begin
            cnt_d[sel_q] = inc_s;
            if (inc_c) ovf_d[sel_q] = 1'b1;
            ptr_d = (sel_q == SW'(NCH-1)) ? '0 : sel_q + SW'(1);
         end
      endcase
      // Clear overrides a coincident write-back on the same channel
      for (int k = 0; k < NCH; k++) begin
         if (bus.clr[k]) begin
            cnt_d[k] = '0;
            ovf_d[k] = 1'b0;
         end
      end
   end

   assign bus.gnt  = gnt_q;
   assign bus.busy = busy_q;
   assign bus.cnt  = cnt_q;
   assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_inc_share_arbiter.sv
// Scoreboard bench: expected grants queued at request time,
// popped and compared whenever the DUT shows a grant.
module tb_inc_share_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;

   inc_share_arbiter_if #(.NCH(4), .W(4)) bus ();

   inc_share_arbiter #(.NCH(4), .W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int         n_vec = 0;
   int         n_err = 0;
   logic [3:0] sb[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      chk("busy", 32'(bus.busy), 32'(bus.gnt != 4'b0));
      if (bus.gnt != 4'b0) begin
         if (sb.size() == 0) chk("gnt_unexp", 32'(bus.gnt), 32'h0);
         else chk("gnt", 32'(bus.gnt), 32'(sb.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      bus.req = '0;
      bus.clr = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_gnt();
      int n = 0;
      do begin
         tick();
         n++;
      end while (bus.gnt == 4'b0 && n < 20);
      if (bus.gnt == 4'b0) chk("wait_gnt", 32'h0, 32'h1);
   endtask

   task automatic req_once(input int ch);
      bus.req = 4'(1 << ch);
      sb.push_back(4'(1 << ch));
      wait_gnt();
      bus.req = '0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.req = '0;
      bus.clr = '0;
      do_reset();

      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle", {7'b0, bus.gnt, bus.busy, bus.ovf, bus.cnt},
             32'h0);
      end

      req_once(0);
      chk("single_cnt", 32'(bus.cnt), 32'h0001);
      chk("single_ovf", 32'(bus.ovf), 32'h0);

      do_reset();
      bus.req = 4'b1111;
      for (int g = 0; g < 8; g++) begin
         sb.push_back(4'(1 << (g % 4)));
         wait_gnt();
         if (g == 7) bus.req = '0;
         tick();
         chk("rr_gap", 32'(bus.gnt), 32'h0);
      end
      chk("rr_cnt", 32'(bus.cnt), 32'h2222);

      do_reset();
      for (int i = 0; i < 15; i++) req_once(2);
      chk("wrap15_cnt", 32'(bus.cnt), 32'h0F00);
      chk("wrap15_ovf", 32'(bus.ovf), 32'h0);
      req_once(2);
      chk("wrap_cnt", 32'(bus.cnt), 32'h0000);
      chk("wrap_ovf", 32'(bus.ovf), 32'h4);
      req_once(2);
      chk("wrap2_cnt", 32'(bus.cnt), 32'h0100);
      chk("wrap2_ovf", 32'(bus.ovf), 32'h4);
      bus.clr = 4'b0100;
      tick();
      bus.clr = '0;
      chk("clr_cnt", 32'(bus.cnt), 32'h0);
      chk("clr_ovf", 32'(bus.ovf), 32'h0);

      do_reset();
      for (int i = 0; i < 7; i++) req_once(1);
      chk("pre_coll", 32'(bus.cnt), 32'h0070);
      bus.req = 4'b0010;
      sb.push_back(4'b0010);
      wait_gnt();
      bus.clr = 4'b0010;
      bus.req = 4'b1111;
      sb.push_back(4'b0100);
      tick();
      bus.clr = '0;
      chk("coll_cnt", 32'(bus.cnt), 32'h0);
      chk("coll_ovf", 32'(bus.ovf), 32'h0);
      wait_gnt();
      bus.req = '0;
      tick();
      chk("coll_next", 32'(bus.cnt), 32'h0100);

      do_reset();
      for (int i = 0; i < 5; i++) req_once(3);
      chk("pre_rst", 32'(bus.cnt), 32'h5000);
      bus.req = 4'b1000;
      sb.push_back(4'b1000);
      wait_gnt();
      rst     = 1'b1;
      bus.req = 4'b1111;
      tick();
      rst = 1'b0;
      chk("mid_rst", {7'b0, bus.gnt, bus.busy, bus.ovf, bus.cnt},
          32'h0);
      sb.push_back(4'b0001);
      wait_gnt();
      bus.req = '0;
      tick();
      chk("post_rst", 32'(bus.cnt), 32'h0001);

      tick();
      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end
endmodule
